// File: rtl/jacaranda_pkg.sv
// Shared types and constants for the UART-to-Wishbone program loader.
// CSUM exists only when LOADER_CHECKSUM_EN is defined.
package jacaranda_pkg;

    localparam logic [7:0] HDR_BYTE    = 8'hA5;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_HDR     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_CSUM    = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WB_REQ,
        WB_WAIT,
`ifdef LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERR
    } state_t;

    // Instruction-memory words are 32 bits wide; the index wraps at 256 words.
    function automatic logic [31:0] instr_addr(input logic [31:0] base, input logic [7:0] idx);
        return base + {22'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/wb_single_write.sv
// One-shot Wishbone single write with an ack timeout.
// Latency: bus request on the edge after start; ack_ok/timeout are combinational in the last bus cycle.
// Backpressure: the cycle is held stable until ack or until ACK_TIMEOUT cycles elapse.
module wb_single_write #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start,
    input  logic [31:0] start_adr,
    input  logic [31:0] start_dat,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    output logic        ack_ok,
    output logic        timeout
);

    logic        active;
    logic [15:0] wait_cnt;

    assign wbm_cyc_o = active;
    assign wbm_stb_o = active;
    assign wbm_we_o  = active;

    assign ack_ok  = active && wbm_ack_i;
    // The cycle where wait_cnt hits ACK_TIMEOUT-1 is the last one allowed on the bus.
    assign timeout = active && !wbm_ack_i && (wait_cnt == 16'(ACK_TIMEOUT - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            active    <= 1'b0;
            wait_cnt  <= 16'd0;
            wbm_sel_o <= 4'b0000;
            wbm_adr_o <= 32'd0;
            wbm_dat_o <= 32'd0;
        end else if (start) begin
            active    <= 1'b1;
            wait_cnt  <= 16'd0;
            wbm_sel_o <= 4'b0001;
            wbm_adr_o <= start_adr;
            wbm_dat_o <= start_dat;
        end else if (ack_ok || timeout) begin
            active    <= 1'b0;
        end else if (active) begin
            wait_cnt  <= wait_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/wb_prog_loader.sv
// UART framed program loader writing bytes into instruction memory over Wishbone; optional LOADER_CHECKSUM_EN.
// Latency: one Wishbone write per data byte, issued the edge after the byte is taken.
// Backpressure: rx_ready drops while a write is outstanding; the bus waits on ack up to ACK_TIMEOUT.
module wb_prog_loader
    import jacaranda_pkg::*;
#(
    parameter logic [31:0] INSTR_BASE  = 32'h3000_0000,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    output logic        cpu_reset_o,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err
);

    state_t      state, state_nxt;
    logic [7:0]  len, len_nxt;
    logic [8:0]  idx, idx_nxt;
    logic [1:0]  err_nxt;
    logic        wb_start;
    logic        ack_ok, timeout;
    logic        byte_fire;
    logic [8:0]  frame_len;
    logic [8:0]  idx_inc;
    logic        last_byte;
    logic        rdy_nxt, busy_nxt, done_nxt, hold_nxt;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  sum, sum_nxt;
`endif

    assign byte_fire = rx_valid && rx_ready;
    // A length byte of zero encodes a full 256-byte frame.
    assign frame_len = {(len == 8'd0), len};
    assign idx_inc   = idx + 9'd1;
    assign last_byte = (idx_inc == frame_len);

    wb_single_write #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_wb_write (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .start     (wb_start),
        .start_adr (instr_addr(INSTR_BASE, idx[7:0])),
        .start_dat ({24'h0, rx_data}),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_i (wbm_ack_i),
        .ack_ok    (ack_ok),
        .timeout   (timeout)
    );

    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        idx_nxt   = idx;
        err_nxt   = err;
        wb_start  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_nxt   = sum;
`endif
        case (state)
            IDLE: begin
                if (byte_fire) begin
                    if (rx_data == HDR_BYTE) begin
                        state_nxt = LEN;
                    end else begin
                        state_nxt = ERR;
                        err_nxt   = ERR_HDR;
                    end
                end
            end
            LEN: begin
                if (byte_fire) begin
                    len_nxt   = rx_data;
                    idx_nxt   = 9'd0;
`ifdef LOADER_CHECKSUM_EN
                    sum_nxt   = 8'd0;
`endif
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (byte_fire) begin
                    wb_start  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_nxt   = sum + rx_data;
`endif
                    state_nxt = WB_REQ;
                end
            end
            WB_REQ, WB_WAIT: begin
                if (ack_ok) begin
                    idx_nxt = idx_inc;
                    if (last_byte) begin
`ifdef LOADER_CHECKSUM_EN
                        state_nxt = CSUM;
`else
                        state_nxt = DONE;
`endif
                    end else begin
                        state_nxt = DATA;
                    end
                end else if (timeout) begin
                    state_nxt = ERR;
                    err_nxt   = ERR_TIMEOUT;
                end else begin
                    state_nxt = WB_WAIT;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (byte_fire) begin
                    if (rx_data == sum) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = ERR;
                        err_nxt   = ERR_CSUM;
                    end
                end
            end
`endif
            DONE: begin
                state_nxt = IDLE;
            end
            ERR: begin
                // Only a fresh header gets out of the error state.
                if (byte_fire && rx_data == HDR_BYTE) begin
                    err_nxt   = ERR_NONE;
                    state_nxt = LEN;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_comb begin
        rdy_nxt  = 1'b0;
        busy_nxt = 1'b1;
        done_nxt = 1'b0;
        hold_nxt = 1'b1;
        case (state_nxt)
            IDLE: begin
                rdy_nxt  = 1'b1;
                busy_nxt = 1'b0;
                hold_nxt = 1'b0;
            end
            LEN, DATA: rdy_nxt = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            CSUM: rdy_nxt = 1'b1;
`endif
            DONE: begin
                busy_nxt = 1'b0;
                done_nxt = 1'b1;
            end
            ERR: begin
                rdy_nxt  = 1'b1;
                busy_nxt = 1'b0;
            end
            default: begin
                rdy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            len         <= 8'd0;
            idx         <= 9'd0;
            err         <= ERR_NONE;
            rx_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cpu_reset_o <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum         <= 8'd0;
`endif
        end else begin
            state       <= state_nxt;
            len         <= len_nxt;
            idx         <= idx_nxt;
            err         <= err_nxt;
            rx_ready    <= rdy_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            cpu_reset_o <= hold_nxt;
`ifdef LOADER_CHECKSUM_EN
            sum         <= sum_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_wb_prog_loader.sv
// Scoreboard bench for wb_prog_loader: expected writes/done pulses are queued, a monitor pops them.
module tb_wb_prog_loader;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i = 1'b0;
    logic        cpu_reset_o, busy, done;
    logic [1:0]  err;

    wb_prog_loader #(
        .INSTR_BASE  (BASE),
        .ACK_TIMEOUT (8)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_ack_i   (wbm_ack_i),
        .cpu_reset_o (cpu_reset_o),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        bit          is_done;
        logic [31:0] adr;
        logic [31:0] dat;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  fails  = 0;
    bit  ack_en = 1'b1;
    int  cyc_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_wr(input int idx, input logic [7:0] b);
        ev_t e;
        e.is_done = 1'b0;
        e.adr     = BASE + 32'(idx * 4);
        e.dat     = {24'h0, b};
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        ev_t e;
        e.is_done = 1'b1;
        e.adr     = 32'd0;
        e.dat     = 32'd0;
        exp_q.push_back(e);
    endtask

    task automatic expect_event(input bit is_done, input logic [31:0] adr, input logic [31:0] dat);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_event: got is_done=%0d adr=%h dat=%h, scoreboard empty", is_done, adr, dat);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(is_done), 32'(e.is_done));
            if (!is_done && !e.is_done) begin
                check("wb_adr", adr, e.adr);
                check("wb_dat", dat, e.dat);
            end
        end
    endtask

    // Slave: single-cycle ack, only when enabled.
    always @(posedge wb_clk_i) begin
        #1;
        wbm_ack_i = ack_en && wbm_cyc_o && wbm_stb_o && !wbm_ack_i;
    end

    // Monitor
    always @(negedge wb_clk_i) begin
        if (wbm_cyc_o) cyc_cycles++;
        if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
            check("wb_sel", 32'(wbm_sel_o), 32'h1);
            check("wb_we", 32'(wbm_we_o), 32'h1);
            expect_event(1'b0, wbm_adr_o, wbm_dat_o);
        end
        if (done && !wb_rst_i) expect_event(1'b1, 32'd0, 32'd0);
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge wb_clk_i);
        while (!rx_ready && n < 200) begin
            @(negedge wb_clk_i);
            n++;
        end
        if (n >= 200) begin
            checks++;
            fails++;
            $display("FAIL rx_ready_wait: got rx_ready=0 for %0d cycles, required 1", n);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        rx_valid = 1'b0;
    endtask

    task automatic wait_quiet();
        int n = 0;
        repeat (2) @(negedge wb_clk_i);
        while ((busy || wbm_cyc_o) && n < 2000) begin
            @(negedge wb_clk_i);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            fails++;
            $display("FAIL quiet_wait: got busy=%0d cyc=%0d, required both 0", busy, wbm_cyc_o);
        end
        repeat (2) @(negedge wb_clk_i);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c0;

        // Reset values
        repeat (3) @(negedge wb_clk_i);
        check("rst_rx_ready", 32'(rx_ready), 0);
        check("rst_cyc", 32'(wbm_cyc_o), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_cpu_reset", 32'(cpu_reset_o), 0);
        check("rst_sel", 32'(wbm_sel_o), 0);
        check("rst_adr", wbm_adr_o, 0);
        check("rst_dat", wbm_dat_o, 0);
        wb_rst_i = 1'b0;

        // Three-byte frame
        push_wr(0, 8'h11); push_wr(1, 8'h22); push_wr(2, 8'h33); push_done();
        send_byte(8'hA5);
        check("hdr_cpu_reset", 32'(cpu_reset_o), 1);
        check("hdr_busy", 32'(busy), 1);
        send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h66);
`endif
        wait_quiet();
        check("frame3_err", 32'(err), 0);
        check("frame3_cpu_reset", 32'(cpu_reset_o), 0);
        check("frame3_pending", 32'(exp_q.size()), 0);

        // Bad header, then recovery
        c0 = cyc_cycles;
        send_byte(8'h5A);
        repeat (3) @(negedge wb_clk_i);
        check("badhdr_err", 32'(err), 1);
        check("badhdr_no_cycle", 32'(cyc_cycles - c0), 0);
        push_wr(0, 8'h7F); push_done();
        send_byte(8'hA5);
        check("recover_err_cleared", 32'(err), 0);
        send_byte(8'h01); send_byte(8'h7F);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h7F);
`endif
        wait_quiet();
        check("recover_err", 32'(err), 0);
        check("recover_pending", 32'(exp_q.size()), 0);

        // Two-byte frame: checksum mismatch or plain completion
        push_wr(0, 8'h01); push_wr(1, 8'h02);
`ifndef LOADER_CHECKSUM_EN
        push_done();
`endif
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h02);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00);
        wait_quiet();
        check("csum_err", 32'(err), 3);
`else
        wait_quiet();
        check("nocsum_err", 32'(err), 0);
`endif
        check("frame2_pending", 32'(exp_q.size()), 0);

        // Full 256-byte frame
        for (int i = 0; i < 256; i++) push_wr(i, 8'(i));
        push_done();
        send_byte(8'hA5); send_byte(8'h00);
        for (int i = 0; i < 256; i++) send_byte(8'(i));
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h80);
`endif
        wait_quiet();
        check("frame256_err", 32'(err), 0);
        check("frame256_pending", 32'(exp_q.size()), 0);

        // Ack timeout
        ack_en = 1'b0;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h55);
        n = 0;
        while (wbm_cyc_o && n < 50) begin
            n++;
            @(negedge wb_clk_i);
        end
        check("timeout_cycles", 32'(n), 8);
        check("timeout_err", 32'(err), 2);
        check("timeout_cpu_reset", 32'(cpu_reset_o), 1);
        check("timeout_busy", 32'(busy), 0);

        // Reset during an outstanding write
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h44);
        repeat (2) @(negedge wb_clk_i);
        check("midwait_cyc", 32'(wbm_cyc_o), 1);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        check("rstmid_cyc", 32'(wbm_cyc_o), 0);
        check("rstmid_stb", 32'(wbm_stb_o), 0);
        check("rstmid_busy", 32'(busy), 0);
        check("rstmid_err", 32'(err), 0);
        wb_rst_i = 1'b0;
        ack_en = 1'b1;
        push_wr(0, 8'hAA); push_wr(1, 8'hBB); push_done();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h65);
`endif
        wait_quiet();
        check("after_rst_err", 32'(err), 0);
        check("final_pending", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
